// File: rtl/dstack.sv
// dstack: data stack storage held as a registered shift array.
// Applies one movement/rotate decision per cycle from dstack_control and
// returns the top three entries plus a combinational random-access read.
module dstack #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [4:0]            rotate_addr,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [5:0]            count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [5:0] DEPTH_C = 6'(DEPTH);

    localparam logic [1:0] MV_REPLACE = 2'b00;
    localparam logic [1:0] MV_PUSH    = 2'b01;
    localparam logic [1:0] MV_POP1    = 2'b10;
    localparam logic [1:0] MV_POP2    = 2'b11;

    logic [WORD_WIDTH-1:0] s    [DEPTH];
    logic [WORD_WIDTH-1:0] s_nx [DEPTH];
    logic [5:0]            cnt_nx;
    logic                  ovf_set;
    logic                  unf_set;
    logic [5:0]            addr_ext;

    assign addr_ext = {1'b0, rotate_addr};

    assign top    = s[0];
    assign second = s[1];
    assign third  = s[2];

    // Random-access read of entry rotate_addr; addresses past the array read 0.
    always_comb begin
        rotate_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rotate_addr == 5'(i)) begin
                rotate_value = s[i];
            end
        end
    end

    // Next array contents, count and flag events for this cycle's decision.
    always_comb begin
        s_nx    = s;
        cnt_nx  = count;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (rotate) begin
            // Entry a moves to the top, entries above it slide down one slot.
            s_nx[0] = rotate_value;
            for (int i = 1; i < DEPTH; i++) begin
                if (6'(i) <= addr_ext) begin
                    s_nx[i] = s[i-1];
                end
            end
            // Empty stack with a==0 is a harmless no-op, not an underflow.
            if ((addr_ext >= count) && ((count != 6'd0) || (addr_ext != 6'd0))) begin
                unf_set = 1'b1;
            end
        end else begin
            s_nx[0] = next_top;
            case (movement)
                MV_REPLACE: begin
                    if (count == 6'd0) begin
                        cnt_nx = 6'd1;
                    end
                end
                MV_PUSH: begin
                    for (int i = 1; i < DEPTH; i++) begin
                        s_nx[i] = s[i-1];
                    end
                    if (count == DEPTH_C) begin
                        ovf_set = 1'b1;
                    end else begin
                        cnt_nx = count + 6'd1;
                    end
                end
                MV_POP1: begin
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        s_nx[i] = s[i+1];
                    end
                    s_nx[DEPTH-1] = '0;
                    if (count == 6'd0) begin
                        unf_set = 1'b1;
                    end else begin
                        cnt_nx = count - 6'd1;
                    end
                end
                MV_POP2: begin
                    for (int i = 1; i < DEPTH - 2; i++) begin
                        s_nx[i] = s[i+2];
                    end
                    s_nx[DEPTH-2] = '0;
                    s_nx[DEPTH-1] = '0;
                    if (count < 6'd2) begin
                        unf_set = 1'b1;
                        cnt_nx  = 6'd0;
                    end else begin
                        cnt_nx = count - 6'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; halt freezes everything, flags stay set until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= '0;
            end
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!halt) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= s_nx[i];
            end
            count     <= cnt_nx;
            overflow  <= overflow | ovf_set;
            underflow <= underflow | unf_set;
        end
    end

endmodule
